// File: rtl/config_frame_assembler.sv
// config_frame_assembler
// Receive side of the self-configuration word stream. The parser waits for
// the sync word, then takes one header word (the frame address) followed by
// NUMBER_OF_ROWS data words. It then emits a one-cycle long-frame strobe with
// the assembled frame and its address.
//
// State table
//   IDLE   | not synced; only the sync word is recognised
//   HEADER | synced; next word is a header (or a desync/redundant sync)
//   DATA   | collecting data words; every word is taken as frame data
//
// Ports
//   clk_system_i        system clock, rising edge
//   reset_n_i           asynchronous active-low reset
//   write_data_i        32-bit configuration word
//   write_strobe_i      word valid, one word per high cycle
//   frame_data_o        assembled frame, first word in the MSBs
//   frame_address_o     header word of the current/last frame
//   long_frame_strobe_o one-cycle pulse when a frame completes
//   synced_o            high while the parser is not IDLE
//   frame_count_o       completed frames since reset (wraps)
module config_frame_assembler #(
    parameter int          NUMBER_OF_ROWS = 4,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter int          DESYNC_FLAG    = 20
) (
    input  logic                         clk_system_i,
    input  logic                         reset_n_i,
    input  logic [31:0]                  write_data_i,
    input  logic                         write_strobe_i,
    output logic [NUMBER_OF_ROWS*32-1:0] frame_data_o,
    output logic [31:0]                  frame_address_o,
    output logic                         long_frame_strobe_o,
    output logic                         synced_o,
    output logic [15:0]                  frame_count_o
);

    localparam int FRAME_W = NUMBER_OF_ROWS * 32;
    localparam int ROW_W   = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUMBER_OF_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [ROW_W-1:0]     row, row_next;
    logic [FRAME_W-1:0]   frame_shifted, frame_data_next;
    logic [31:0]          frame_address_next;
    logic [15:0]          frame_count_next;
    logic                 frame_done;

    generate
        if (NUMBER_OF_ROWS == 1) begin : g_single_row
            assign frame_shifted = write_data_i;
        end else begin : g_multi_row
            assign frame_shifted = {frame_data_o[FRAME_W-33:0], write_data_i};
        end
    endgenerate

    always_comb begin
        state_next         = state;
        row_next           = row;
        frame_data_next    = frame_data_o;
        frame_address_next = frame_address_o;
        frame_count_next   = frame_count_o;
        frame_done         = 1'b0;

        if (write_strobe_i) begin
            case (state)
                IDLE: begin
                    if (write_data_i == SYNC_WORD) begin
                        state_next = HEADER;
                    end
                end
                HEADER: begin
                    // The default sync word itself has the desync bit set, so
                    // the sync compare must win or a redundant sync would drop
                    // the link.
                    if (write_data_i == SYNC_WORD) begin
                        state_next = HEADER;
                    end else if (write_data_i[DESYNC_FLAG]) begin
                        state_next = IDLE;
                    end else begin
                        frame_address_next = write_data_i;
                        row_next           = '0;
                        state_next         = DATA;
                    end
                end
                DATA: begin
                    frame_data_next = frame_shifted;
                    if (row == LAST_ROW) begin
                        frame_done       = 1'b1;
                        frame_count_next = frame_count_o + 16'd1;
                        row_next         = '0;
                        state_next       = HEADER;
                    end else begin
                        row_next = row + ROW_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state               <= IDLE;
            row                 <= '0;
            frame_data_o        <= '0;
            frame_address_o     <= '0;
            frame_count_o       <= '0;
            long_frame_strobe_o <= 1'b0;
            synced_o            <= 1'b0;
        end else begin
            state               <= state_next;
            row                 <= row_next;
            frame_data_o        <= frame_data_next;
            frame_address_o     <= frame_address_next;
            frame_count_o       <= frame_count_next;
            long_frame_strobe_o <= frame_done;
            synced_o            <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_config_frame_assembler.sv
module tb_config_frame_assembler;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic         clk;
    logic         rst_n;
    logic [31:0]  wdata;
    logic         wstrobe;
    logic [127:0] frame_data;
    logic [31:0]  frame_address;
    logic         long_strobe;
    logic         synced;
    logic [15:0]  frame_count;

    config_frame_assembler dut (
        .clk_system_i        (clk),
        .reset_n_i           (rst_n),
        .write_data_i        (wdata),
        .write_strobe_i      (wstrobe),
        .frame_data_o        (frame_data),
        .frame_address_o     (frame_address),
        .long_frame_strobe_o (long_strobe),
        .synced_o            (synced),
        .frame_count_o       (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic [31:0]  addr;
        logic [15:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   strobes   = 0;
    int   exp_total = 0;
    logic [15:0] exp_count = 16'd0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected frame per strobe cycle.
    always @(negedge clk) begin
        if (rst_n && long_strobe) begin
            exp_t e;
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got strobe with addr %0h expected none", frame_address);
            end else begin
                e = exp_q.pop_front();
                chk("frame_data", frame_data, e.data);
                chk("frame_address", {96'd0, frame_address}, {96'd0, e.addr});
                chk("frame_count", {112'd0, frame_count}, {112'd0, e.cnt});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] w);
        wdata   = w;
        wstrobe = 1'b1;
        @(posedge clk);
        #1;
        wstrobe = 1'b0;
        wdata   = 32'hDEAD_BEEF;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input logic [127:0] exp_data,
                              input int gapped);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        put(hdr);
        for (int i = 0; i < 4; i++) begin
            if (gapped != 0) idle((i * 5) % 6);
            if (i == 3) begin
                exp_count = exp_count + 16'd1;
                exp_q.push_back('{data: exp_data, addr: hdr, cnt: exp_count});
                exp_total++;
            end
            put(w[i]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wstrobe = 1'b0;
        wdata   = 32'h0;
        #22;
        rst_n = 1'b1;
        idle(1);

        // reset state and junk words while unsynced
        chk("rst_frame_data", frame_data, 128'd0);
        chk("rst_addr", {96'd0, frame_address}, 128'd0);
        chk("rst_strobe", {127'd0, long_strobe}, 128'd0);
        chk("rst_synced", {127'd0, synced}, 128'd0);
        chk("rst_count", {112'd0, frame_count}, 128'd0);
        put(32'h1234_5678);
        put(32'h0000_0000);
        idle(1);
        chk("idle_synced", {127'd0, synced}, 128'd0);
        chk("idle_data", frame_data, 128'd0);

        // single frame, one word per cycle
        put(SYNC);
        chk("sync_rise", {127'd0, synced}, 128'd1);
        send_frame(32'h0000_0003, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 32'hC0C0_C0C0,
                   32'hD0D0_D0D0, 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0, 0);
        chk("strobe_timing", {127'd0, long_strobe}, 128'd1);
        idle(1);
        chk("strobe_one_cycle", {127'd0, long_strobe}, 128'd0);
        chk("data_hold", frame_data, 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0);

        // redundant sync in HEADER, then gapped frame
        put(SYNC);
        chk("redundant_sync", {127'd0, synced}, 128'd1);
        idle(2);
        send_frame(32'h0000_0007, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 32'hC0C0_C0C0,
                   32'hD0D0_D0D0, 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0, 1);

        // back-to-back header; control-looking data words
        send_frame(32'h0000_0011, SYNC, 32'h0010_0000, 32'h1234_5678, SYNC,
                   128'hFAB0FAB1_00100000_12345678_FAB0FAB1, 0);
        chk("ctl_data_synced", {127'd0, synced}, 128'd1);

        // desync, ignored data, resync
        put(32'h0010_0000);
        chk("desync_synced", {127'd0, synced}, 128'd0);
        chk("desync_addr", {96'd0, frame_address}, {96'd0, 32'h0000_0011});
        for (int i = 0; i < 6; i++) put(32'h5555_0000 + i);
        chk("ignored_synced", {127'd0, synced}, 128'd0);
        chk("ignored_count", {112'd0, frame_count}, 128'd3);
        put(SYNC);
        send_frame(32'h0000_0020, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
                   32'h0000_0004, 128'h00000001_00000002_00000003_00000004, 0);
        idle(1);
        chk("resync_count", {112'd0, frame_count}, 128'd4);

        // reset in the middle of a frame
        put(32'h0000_0033);
        put(32'h1111_1111);
        put(32'h2222_2222);
        rst_n = 1'b0;
        exp_count = 16'd0;
        #1;
        chk("midrst_data", frame_data, 128'd0);
        chk("midrst_addr", {96'd0, frame_address}, 128'd0);
        chk("midrst_synced", {127'd0, synced}, 128'd0);
        chk("midrst_count", {112'd0, frame_count}, 128'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        put(SYNC);
        send_frame(32'h0000_0042, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003,
                   32'hCAFE_0004, 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004, 0);
        idle(3);
        chk("post_rst_count", {112'd0, frame_count}, 128'd1);

        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        chk("strobe_total", 128'(strobes), 128'(exp_total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
